fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_sequencer_if.sv | 51 +++++
 rtl/fetch_sequencer_byte_assembler.sv | 39 +++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Imported by the sequencer, its byte assembler and its bus interface.
package fetch_pkg;

    localparam int INST_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_INST = 4;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [INST_W-1:0] pc_inc(
        input logic [INST_W-1:0] pc
    );
        return pc + 32'd4;
    endfunction

    function automatic logic [INST_W-1:0] word_align(
        input logic [INST_W-1:0] addr
    );
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory, redirect and decode-side signals of the fetch sequencer.
// master = sequencer side, slave = memory/execute/decode environment.
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
);

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_rd_data;

    logic              redirect_valid;
    logic [INST_W-1:0] redirect_addr;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [INST_W-1:0] inst_pc;
    logic [INST_W-1:0] next_pc;
    logic              inst_fault;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        input  redirect_valid,
        input  redirect_addr,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        output next_pc,
        output inst_fault
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        output redirect_valid,
        output redirect_addr,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        input  next_pc,
        input  inst_fault
    );

endinterface

// File: rtl/fetch_sequencer_byte_assembler.sv
// Four-byte capture register: byte k lands in bits [31-8k -: 8].
// word_nxt exposes the word including this cycle's byte for same-edge loads.
module byte_assembler
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld_en,
    input  logic [1:0]        idx,
    input  logic [BYTE_W-1:0] din,
    output logic [INST_W-1:0] word,
    output logic [INST_W-1:0] word_nxt
);

    always_comb begin
        word_nxt = word;
        if (ld_en) begin
            unique case (idx)
                2'd0: word_nxt[31:24] = din;
                2'd1: word_nxt[23:16] = din;
                2'd2: word_nxt[15:8]  = din;
                2'd3: word_nxt[7:0]   = din;
                default: word_nxt = word;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= NOP_INST;
        end else if (clr) begin
            word <= NOP_INST;
        end else begin
            word <= word_nxt;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC and sequences four byte reads per instruction, handing
// big-endian words to decode over valid/ready; redirects abort in-flight fetches.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                MEM_BYTES = 28,
    parameter logic [INST_W-1:0] RESET_PC  = 32'h0000_0000
)(
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    localparam logic [INST_W-1:0] PC0 = RESET_PC & ~32'h3;

    fetch_state_t      state;
    logic [INST_W-1:0] pc;
    logic [1:0]        cnt;
    logic              armed;
    logic              rd_q;
    logic [1:0]        idx_q;

    logic              valid_q;
    logic [INST_W-1:0] data_q;
    logic [INST_W-1:0] ipc_q;
    logic [INST_W-1:0] npc_q;
    logic              fault_q;

    logic              rd_en;
    logic              fault;
    logic              cap;
    logic              redir;
    logic              xfer;
    logic [INST_W-1:0] tgt;
    logic [INST_W:0]   last_byte;
    logic [INST_W-1:0] word;
    logic [INST_W-1:0] word_nxt;

    // Last byte address of the word at pc, widened so wrap cannot hide a fault.
    assign last_byte = {1'b0, pc} + 33'd3;
    assign fault     = last_byte >= 33'(MEM_BYTES);

    assign redir = bus.redirect_valid;
    assign tgt   = word_align(bus.redirect_addr);
    assign xfer  = valid_q && bus.inst_ready;

    // armed keeps the reset-release cycle from counting as a fetch cycle.
    assign rd_en = armed && (state == FETCH) && !fault;
    assign cap   = rd_q && !redir;

    assign bus.mem_rd_en  = rd_en;
    assign bus.mem_addr   = pc[ADDR_W-1:0] + ADDR_W'(cnt);
    assign bus.inst_valid = valid_q;
    assign bus.inst_data  = data_q;
    assign bus.inst_pc    = ipc_q;
    assign bus.next_pc    = npc_q;
    assign bus.inst_fault = fault_q;

    byte_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (redir),
        .ld_en    (cap),
        .idx      (idx_q),
        .din      (bus.mem_rd_data),
        .word     (word),
        .word_nxt (word_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            rd_q  <= 1'b0;
            idx_q <= 2'd0;
        end else begin
            armed <= 1'b1;
            rd_q  <= rd_en && !redir;
            idx_q <= cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= PC0;
            cnt     <= 2'd0;
            valid_q <= 1'b0;
            data_q  <= NOP_INST;
            ipc_q   <= '0;
            npc_q   <= '0;
            fault_q <= 1'b0;
        end else if (redir) begin
            state   <= FETCH;
            pc      <= tgt;
            cnt     <= 2'd0;
            valid_q <= 1'b0;
        end else if (armed) begin
            unique case (state)
                FETCH: begin
                    if (fault) begin
                        state   <= HOLD;
                        valid_q <= 1'b1;
                        data_q  <= NOP_INST;
                        ipc_q   <= pc;
                        npc_q   <= pc_inc(pc);
                        fault_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state   <= HOLD;
                    valid_q <= 1'b1;
                    data_q  <= word_nxt;
                    ipc_q   <= pc;
                    npc_q   <= pc_inc(pc);
                    fault_q <= 1'b0;
                end
                HOLD: begin
                    if (xfer) begin
                        state   <= FETCH;
                        pc      <= pc_inc(pc);
                        cnt     <= 2'd0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus random bench for fetch_sequencer against a word-level model.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int MEMB = 28;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [7:0] mem [256];

    fetch_sequencer_if #(.ADDR_W(8)) bus ();

    fetch_sequencer #(
        .ADDR_W    (8),
        .MEM_BYTES (MEMB),
        .RESET_PC  (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : 8'hA5;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic exp_flt(input logic [31:0] p);
        return ({1'b0, p} + 33'd3) >= 33'(MEMB);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] p);
        logic [7:0] a;
        a = p[7:0];
        if (exp_flt(p)) return 32'h0;
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n, output int rds,
                              output logic [7:0] fa);
        rds = 0;
        fa  = 8'h0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            bus.redirect_valid = 1'b0;
            if (bus.inst_valid) break;
            if (bus.mem_rd_en) begin
                if (rds == 0) fa = bus.mem_addr;
                rds++;
            end
        end
        chk("valid_seen", bus.inst_valid, 1);
    endtask

    task automatic wait_rd(input logic [7:0] tgt, output logic [7:0] fa);
        logic seen;
        seen = 1'b0;
        fa   = 8'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.redirect_valid = 1'b0;
            if (bus.mem_rd_en) begin
                if (!seen) fa = bus.mem_addr;
                seen = 1'b1;
                if (bus.mem_addr == tgt) break;
            end
        end
        chk("rd_addr_seen", {bus.mem_rd_en, bus.mem_addr}, {1'b1, tgt});
    endtask

    task automatic redirect(input logic [31:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] p);
        chk({tag, "_pc"}, bus.inst_pc, p);
        chk({tag, "_npc"}, bus.next_pc, p + 32'd4);
        chk({tag, "_data"}, bus.inst_data, exp_word(p));
        chk({tag, "_flt"}, bus.inst_fault, exp_flt(p));
    endtask

    initial begin
        int          n;
        int          rds;
        logic [7:0]  fa;
        logic [31:0] epc;
        logic [31:0] t;
        int          idle;
        int          got;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
        mem[4] = 8'h01; mem[5] = 8'h09; mem[6] = 8'h50; mem[7] = 8'h20;

        rst_n              = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_data", bus.inst_data, 0);
        chk("rst_pc", bus.inst_pc, 0);
        chk("rst_npc", bus.next_pc, 0);
        chk("rst_flt", bus.inst_fault, 0);

        // Straight-line fetch from reset.
        rst_n          = 1'b1;
        bus.inst_ready = 1'b1;
        wait_valid(n, rds, fa);
        chk("lat0", n, 5);
        chk("rds0", rds, 4);
        chk("fa0", fa, 8'h00);
        chk("word0", bus.inst_data, 32'h2008_0005);
        chk_inst("i0", 32'h0);
        wait_valid(n, rds, fa);
        chk("period", n + 1, 6);
        chk("word1", bus.inst_data, 32'h0109_5020);
        chk_inst("i1", 32'h4);

        // Back-pressure on the pc=4 instruction.
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.inst_valid, 1);
            chk("bp_data", bus.inst_data, 32'h0109_5020);
            chk("bp_rd_en", bus.mem_rd_en, 0);
        end
        bus.inst_ready = 1'b1;

        // Redirect to 0x0E while byte 2 of the pc=8 fetch is issued.
        wait_rd(8'h0A, fa);
        chk("bp_next_fa", fa, 8'h08);
        redirect(32'h0000_000E);
        wait_valid(n, rds, fa);
        chk("rd_fa", fa, 8'h0C);
        chk("rd_rds", rds, 4);
        chk("rd_lat", n, 5);
        chk_inst("redir", 32'h0C);

        // Redirect coincident with the 0x0C transfer.
        redirect(32'h0000_0004);
        wait_valid(n, rds, fa);
        chk_inst("coinc", 32'h04);

        // Last legal word, then first out-of-range word.
        redirect(32'h0000_0018);
        wait_valid(n, rds, fa);
        chk("legal_rds", rds, 4);
        chk_inst("legal", 32'h18);
        redirect(32'h0000_001C);
        wait_valid(n, rds, fa);
        chk("oor_rds", rds, 0);
        chk("oor_lat", n, 1);
        chk_inst("oor", 32'h1C);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFE);
        wait_valid(n, rds, fa);
        chk("wrap_npc", bus.next_pc, 32'h0);
        chk("wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
        chk("wrap_flt", bus.inst_fault, 1);
        wait_valid(n, rds, fa);
        chk_inst("after_wrap", 32'h0);

        // Async reset while reads are being issued.
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_rd", bus.mem_rd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_en", bus.mem_rd_en, 0);
        chk("arst_valid", bus.inst_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(n, rds, fa);
        chk("arst_fa", fa, 8'h00);
        chk("arst_lat", n, 5);
        chk_inst("arst", 32'h0);

        // Async reset while an instruction is held.
        bus.inst_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("hrst_valid", bus.inst_valid, 0);
        chk("hrst_data", bus.inst_data, 0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.inst_ready = 1'b1;

        // Random ready/redirect traffic against the word-level model.
        epc  = 32'h0;
        idle = 0;
        got  = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.redirect_valid = 1'b0;
            if (bus.inst_valid) begin
                idle = 0;
                got++;
                chk_inst("rnd", epc);
            end else begin
                idle++;
            end
            if (idle > 8) begin
                chk("rnd_stall", bus.inst_valid, 1);
                idle = 0;
            end
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                t = 32'($urandom_range(0, 47));
                redirect(t);
                epc  = word_align(t);
                idle = 0;
            end else if (bus.inst_valid && bus.inst_ready) begin
                epc = epc + 32'd4;
            end
        end
        bus.redirect_valid = 1'b0;
        chk("rnd_deliv", 32'(got > 20), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
